// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline front end.
// Holds the fetch FSM states, the buffered fetch word layout and the reset vector.
package mips_pkg;

    typedef enum logic [1:0] {
        BOOT    = 2'd0,
        REQ     = 2'd1,
        DISCARD = 2'd2
    } fetch_state_e;

    localparam int unsigned INSTR_BYTES  = 4;
    localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
    } fetch_word_t;

endpackage

// File: rtl/pc_fetch_stage_if.sv
// Instruction-memory request/acknowledge bus between fetch and memory.
// The fetch stage is the master; the memory is the slave.
interface pc_fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
    modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/fetch_skid_buf.sv
// Two-entry fetch buffer: an output register facing decode plus one skid entry.
// The skid only fills when a word arrives while decode holds the output register.
module fetch_skid_buf
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  fetch_word_t push_word,
    input  logic        pop,
    input  logic        flush,
    output logic        out_valid,
    output fetch_word_t out_word,
    output logic        skid_valid
);
    fetch_word_t skid_word;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            out_word   <= '0;
            skid_word  <= '0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (pop && skid_valid) begin
            out_word <= skid_word;
            if (push) begin
                skid_word <= push_word;
            end else begin
                skid_valid <= 1'b0;
            end
        end else if (push && (!out_valid || pop)) begin
            out_word  <= push_word;
            out_valid <= 1'b1;
        end else if (push) begin
            skid_word  <= push_word;
            skid_valid <= 1'b1;
        end else if (pop) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: rtl/ripple_adder32.sv
// 32-bit ripple-carry adder that sits downstream of the fetch stage.
// Carry-in is zero and the carry-out is discarded, so the sum wraps modulo 2^32.
module ripple_adder32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] sum
);
    logic carry;

    always_comb begin
        carry = 1'b0;
        sum   = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
    end
endmodule

// File: rtl/pc_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the external next-PC adder and
// fetches over the imem req/ack bus into a two-entry buffer toward decode.
module pc_fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_VECTOR,
    parameter logic [31:0] INC      = 32'(INSTR_BYTES)
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic [31:0]             add_a,
    output logic [31:0]             add_b,
    input  logic [31:0]             add_sum,
    pc_fetch_stage_if.master        imem,
    input  logic                    stall,
    input  logic                    redirect,
    input  logic [31:0]             redirect_pc,
    output logic                    if_valid,
    output logic [31:0]             if_instr,
    output logic [31:0]             if_pc,
    output logic [31:0]             if_pc_plus4
);
    fetch_state_e state, state_nxt;
    logic [31:0]  pc, pc_nxt;
    logic         req, push, pop, skid_valid;
    fetch_word_t  push_word, out_word;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= BOOT;
            pc    <= RESET_PC;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
        end
    end

    // req depends only on registered state so stall/redirect never reach it combinationally
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        req       = 1'b0;
        push      = 1'b0;
        case (state)
            BOOT: state_nxt = REQ;
            REQ: begin
                req = !skid_valid;
                if (imem.imem_ack) begin
                    push   = 1'b1;
                    pc_nxt = add_sum;
                end
            end
            DISCARD: begin
                req = 1'b1;
                if (imem.imem_ack) state_nxt = REQ;
            end
            default: state_nxt = BOOT;
        endcase
        if (redirect) begin
            push   = 1'b0;
            pc_nxt = redirect_pc;
            if (state == DISCARD || (state == REQ && req && !imem.imem_ack)) begin
                state_nxt = DISCARD;
            end else begin
                state_nxt = REQ;
            end
        end
    end

    assign pop       = if_valid && !stall;
    assign push_word = '{instr: imem.imem_rdata, pc: pc, pc_plus4: add_sum};

    fetch_skid_buf u_buf (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_word  (push_word),
        .pop        (pop),
        .flush      (redirect),
        .out_valid  (if_valid),
        .out_word   (out_word),
        .skid_valid (skid_valid)
    );

    assign imem.imem_req  = req;
    assign imem.imem_addr = pc;
    assign add_a          = pc;
    assign add_b          = INC;
    assign if_instr       = out_word.instr;
    assign if_pc          = out_word.pc;
    assign if_pc_plus4    = out_word.pc_plus4;
endmodule

// File: tb/tb_pc_fetch_stage.sv
// Bench for pc_fetch_stage: queue-based reference model of the fetch stream,
// a latency-programmable instruction memory and a second instance near the wrap point.
module tb_pc_fetch_stage;
    import mips_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rst2 = 1'b0;
    always #5 clk = ~clk;

    logic        stall, redirect;
    logic [31:0] redirect_pc;
    logic [31:0] add_a, add_b, add_sum;
    logic        if_valid;
    logic [31:0] if_instr, if_pc, if_pc_plus4;

    logic        stall2, redirect2;
    logic [31:0] redirect_pc2;
    logic [31:0] add_a2, add_b2, add_sum2;
    logic        if_valid2;
    logic [31:0] if_instr2, if_pc2, if_pc_plus42;

    pc_fetch_stage_if bus ();
    pc_fetch_stage_if bus2 ();

    ripple_adder32 u_add  (.a(add_a),  .b(add_b),  .sum(add_sum));
    ripple_adder32 u_add2 (.a(add_a2), .b(add_b2), .sum(add_sum2));

    pc_fetch_stage u_dut (
        .clk(clk), .rst(rst), .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
        .imem(bus.master), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_pc_plus4(if_pc_plus4)
    );

    pc_fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) u_dut2 (
        .clk(clk), .rst(rst2), .add_a(add_a2), .add_b(add_b2), .add_sum(add_sum2),
        .imem(bus2.master), .stall(stall2), .redirect(redirect2), .redirect_pc(redirect_pc2),
        .if_valid(if_valid2), .if_instr(if_instr2), .if_pc(if_pc2), .if_pc_plus4(if_pc_plus42)
    );

    // zero-wait memory for the second instance
    always_comb begin
        bus2.imem_ack   = bus2.imem_req;
        bus2.imem_rdata = bus2.imem_addr ^ 32'hA5A5_A5A5;
    end

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
    } word_t;

    word_t       q[$];
    logic [31:0] m_pc;
    int          phase;     // 0 booting, 1 running, 2 draining a stale request
    int          cnt, lat, lat_fixed;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick_lat();
        return (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 3));
    endfunction

    function automatic logic model_req();
        if (phase == 0) return 1'b0;
        if (phase == 2) return 1'b1;
        return q.size() < 2;
    endfunction

    task automatic model_reset();
        q.delete();
        m_pc  = 32'h0;
        phase = 0;
        cnt   = 0;
        lat   = pick_lat();
    endtask

    task automatic model_step(input logic s, input logic r, input logic [31:0] rp,
                              input logic a, input logic [31:0] rd);
        logic req_m;
        req_m = model_req();
        if (r) begin
            q.delete();
            if (phase == 0) phase = 1;
            else if (phase == 1 && req_m && !a) phase = 2;
            m_pc = rp;
        end else begin
            if (q.size() > 0 && !s) void'(q.pop_front());
            if (phase == 1 && a) begin
                q.push_back('{rd, m_pc, m_pc + 32'd4});
                m_pc = m_pc + 32'd4;
            end else if (phase == 2 && a) begin
                phase = 1;
            end else if (phase == 0) begin
                phase = 1;
            end
        end
    endtask

    // Called just after a rising edge; drives one cycle of inputs and memory response.
    task automatic cycle(input logic s, input logic r, input logic [31:0] rp);
        logic        a;
        logic [31:0] rd;
        stall       = s;
        redirect    = r;
        redirect_pc = rp;
        a  = bus.imem_req && (cnt >= lat);
        rd = bus.imem_addr ^ 32'hA5A5_A5A5;
        bus.imem_ack   = a;
        bus.imem_rdata = rd;
        @(posedge clk);
        model_step(s, r, rp, a, rd);
        if (a) begin
            cnt = 0;
            lat = pick_lat();
        end else if (bus.imem_req) begin
            cnt++;
        end
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("if_valid", 32'(if_valid), 32'(q.size() > 0));
            if (q.size() > 0) begin
                check("if_instr", if_instr, q[0].instr);
                check("if_pc", if_pc, q[0].pc);
                check("if_pc_plus4", if_pc_plus4, q[0].pc4);
            end
            check("imem_req", 32'(bus.imem_req), 32'(model_req()));
            check("imem_addr", bus.imem_addr, m_pc);
            check("add_a", add_a, m_pc);
            check("add_b", add_b, 32'd4);
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_if_valid"}, 32'(if_valid), 32'd0);
        check({tag, "_imem_req"}, 32'(bus.imem_req), 32'd0);
        check({tag, "_imem_addr"}, bus.imem_addr, 32'h0);
        check({tag, "_add_a"}, add_a, 32'h0);
        check({tag, "_add_b"}, add_b, 32'd4);
        check({tag, "_if_instr"}, if_instr, 32'h0);
        check({tag, "_if_pc"}, if_pc, 32'h0);
        check({tag, "_if_pc_plus4"}, if_pc_plus4, 32'h0);
    endtask

    initial begin
        int n;
        logic [31:0] rp;
        stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        stall2 = 1'b0; redirect2 = 1'b0; redirect_pc2 = '0;
        bus.imem_ack = 1'b0; bus.imem_rdata = '0;
        lat_fixed = 0;
        model_reset();
        #1 rst = 1'b1; rst2 = 1'b1;
        #1 chk_en = 1'b1;
        check_reset_outputs("reset");
        @(posedge clk); @(posedge clk); #1 rst = 1'b0;

        // boot then zero-wait streaming
        cycle(1'b0, 1'b0, '0);
        check("first_req", 32'(bus.imem_req), 32'd1);
        check("first_addr", bus.imem_addr, 32'h0);
        cycle(1'b0, 1'b0, '0);
        check("w0_valid", 32'(if_valid), 32'd1);
        check("w0_pc", if_pc, 32'h0);
        check("w0_instr", if_instr, 32'hA5A5_A5A5);
        check("w0_pc4", if_pc_plus4, 32'h4);
        cycle(1'b0, 1'b0, '0);
        check("w1_pc", if_pc, 32'h4);
        check("w1_instr", if_instr, 32'hA5A5_A5A1);
        cycle(1'b0, 1'b0, '0);
        check("w2_pc", if_pc, 32'h8);

        // stall: 0xC lands in the skid, request drops
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, '0);
            check("stall_hold_pc", if_pc, 32'h8);
            check("stall_req_low", 32'(bus.imem_req), 32'd0);
        end
        cycle(1'b0, 1'b0, '0);
        check("unstall_pc_c", if_pc, 32'hC);
        cycle(1'b0, 1'b0, '0);
        check("unstall_pc_10", if_pc, 32'h10);

        // redirect coinciding with ack
        cycle(1'b0, 1'b1, 32'h10);
        check("redir_addr_10", bus.imem_addr, 32'h10);
        cycle(1'b0, 1'b1, 32'h80);
        check("redir_ack_valid", 32'(if_valid), 32'd0);
        check("redir_ack_addr", bus.imem_addr, 32'h80);
        cycle(1'b0, 1'b0, '0);
        check("redir_ack_pc", if_pc, 32'h80);

        // redirect while a 2-cycle request is outstanding
        cycle(1'b0, 1'b1, 32'h20);
        lat_fixed = 2; lat = 2;
        cycle(1'b0, 1'b0, '0);
        cycle(1'b0, 1'b1, 32'h400);
        check("discard_addr", bus.imem_addr, 32'h400);
        check("discard_req", 32'(bus.imem_req), 32'd1);
        check("discard_valid", 32'(if_valid), 32'd0);
        cycle(1'b0, 1'b0, '0);
        check("stale_dropped", 32'(if_valid), 32'd0);
        n = 0;
        while (!if_valid && n < 10) begin
            cycle(1'b0, 1'b0, '0);
            n++;
        end
        check("after_discard_valid", 32'(if_valid), 32'd1);
        check("after_discard_pc", if_pc, 32'h400);
        check("after_discard_instr", if_instr, 32'h400 ^ 32'hA5A5_A5A5);

        // redirect plus stall with a full skid
        lat_fixed = 0; lat = 0;
        cycle(1'b1, 1'b0, '0);
        check("skid_full_req", 32'(bus.imem_req), 32'd0);
        cycle(1'b1, 1'b1, 32'h1000);
        check("flush_valid", 32'(if_valid), 32'd0);
        check("flush_addr", bus.imem_addr, 32'h1000);
        check("flush_req", 32'(bus.imem_req), 32'd1);

        // asynchronous reset in the middle of a wait
        lat_fixed = 3; lat = 3;
        cycle(1'b0, 1'b0, '0);
        cycle(1'b0, 1'b0, '0);
        #2 rst = 1'b1;
        #1 check_reset_outputs("async_rst");
        lat_fixed = -1;
        model_reset();
        bus.imem_ack = 1'b0;
        @(posedge clk); #1 rst = 1'b0;

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rp = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 12)))
                                             : $urandom;
            cycle(1'($urandom_range(0, 9) < 3), 1'($urandom_range(0, 19) == 0), rp);
        end

        // wrap-around instance
        rst2 = 1'b0;
        n = 0;
        while (!if_valid2 && n < 10) begin
            cycle(1'b0, 1'b0, '0);
            n++;
        end
        check("wrap_valid", 32'(if_valid2), 32'd1);
        check("wrap_pc0", if_pc2, 32'hFFFF_FFF8);
        check("wrap_instr0", if_instr2, 32'h5A5A_5A5D);
        check("wrap_pc4_0", if_pc_plus42, 32'hFFFF_FFFC);
        cycle(1'b0, 1'b0, '0);
        check("wrap_pc1", if_pc2, 32'hFFFF_FFFC);
        check("wrap_pc4_1", if_pc_plus42, 32'h0);
        cycle(1'b0, 1'b0, '0);
        check("wrap_pc2", if_pc2, 32'h0);
        check("wrap_pc4_2", if_pc_plus42, 32'h4);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
